fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single 4-bit fifo write port between N_REQ producers.
- Grants one producer at a time for a bounded burst of up to MAX_BURST words.
- Drives the fifo push/d inputs directly and honours the fifo full flag.
- Sits between the producer blocks and the fifo; the fifo read side is untouched.

Parameters:
- N_REQ, 4, number of requesting producers (2..8).
- DW, 4, data width; equals fifo d width.
- MAX_BURST, 4, max words accepted per grant (1..15).
- IW, 2, width of grant_id; must satisfy 2**IW >= N_REQ.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-producer request; high while producer has a word on its din slice.
- din  input  N_REQ*DW  packed producer data; slice i = din[i*DW +: DW].
- fifo_full  input  1  fifo full flag.
- ack  output  N_REQ  one-hot, combinational; word of producer i accepted at this edge.
- fifo_push  output  1  combinational; push to fifo, equals OR of ack.
- fifo_d  output  DW  combinational; din slice of owner when fifo_push=1, else 0.
- grant_id  output  IW  registered; current owner index, 0 when idle.
- busy  output  1  registered; 1 in GRANT state.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, owner=0, last_owner=N_REQ-1, burst_cnt=0, grant_id=0, busy=0. Combinational outputs ack=0, fifo_push=0, fifo_d=0 follow directly.
- FSM, two states:
  - IDLE:
    - If any req bit is set, pick the first set bit scanning last_owner+1, last_owner+2, ... modulo N_REQ.
    - Next edge: owner=pick, grant_id=pick, busy=1, burst_cnt=0, state=GRANT.
    - No transfer in IDLE, so arbitration latency is 1 cycle from req to grant.
  - GRANT:
    - Transfer condition: req[owner]=1 and fifo_full=0. Then ack[owner]=1, fifo_push=1, fifo_d=din[owner].
    - The producer and the fifo both consume the word on that edge.
    - On each transfer, burst_cnt increments.
    - Release to IDLE at the next edge when either:
      - the transfer makes burst_cnt reach MAX_BURST; or
      - req[owner]=0 (no transfer in that cycle).
    - On release: last_owner=owner, grant_id=0, busy=0, burst_cnt=0.
- fifo_full=1 in GRANT: stall. No ack, burst_cnt holds, grant holds; stalled cycles do not count toward the burst.
- Non-owner req bits are ignored during GRANT; they are served at the next arbitration.
- Every grant ends in IDLE for exactly one cycle, so there is one bubble cycle between bursts.
- Fairness: a producer with req held continuously is granted within N_REQ arbitrations.
- A single requester re-wins after its own burst, following the IDLE bubble.
- Producer contract: din slice stable while req high; may change only at an edge where its ack=1. Dropping req without ack is a legal withdrawal.
- At most one ack bit high in any cycle. fifo_push is never 1 while fifo_full=1.
- Reset asserted mid-burst:
  - Immediate return to reset values.
  - ack and fifo_push drop in the same cycle, with no partial push.
  - After reset release, the first arbitration favours req[0].

Test Plan:
- Reset, then req=4'b0001, fifo_full=0, din0 advancing 1,2,3,4,5 on ack → grant_id=0 and busy=1 one cycle after req; pushes 1,2,3,4 on four consecutive edges; busy=0 for one cycle; regrant to 0; push 5.
- req=4'b1111 held, all producers always have data → grants 0,1,2,3,0 in order; each grant gives exactly 4 pushes followed by one idle cycle.
- Owner 2 granted after 2 words, fifo_full=1 for 3 cycles → no ack or push during stall; burst_cnt stays 2; after full drops, 2 more words and then release.
- Owner 1 drops req after 1 word while req3=1 → release next edge with no push; following grant goes to 3, not 0.
- reset=0 asynchronously mid-burst with fifo_push=1 → fifo_push, ack, busy and grant_id go to 0 without waiting for clk; after release with req=4'b1010, first grant goes to 1.
- Drive 17 words through producer 0 into a 16-deep fifo with no pops → full asserts; no push while full; accepted data matches fifo output order after pop begins.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one fifo write port between N_REQ
// producers, granting one producer at a time for a burst of up to
// MAX_BURST words. Every grant is followed by one idle arbitration cycle.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned IW        = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] din,
    input  logic                fifo_full,
    output logic [N_REQ-1:0]    ack,
    output logic                fifo_push,
    output logic [DW-1:0]       fifo_d,
    output logic [IW-1:0]       grant_id,
    output logic                busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0]  LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [IW:0] N_WRAP    = (IW+1)'(N_REQ);

    state_t        state, state_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [IW-1:0] last_owner, last_owner_nxt;
    logic [IW-1:0] grant_id_nxt;
    logic [3:0]    burst_cnt, burst_cnt_nxt;
    logic          busy_nxt;
    logic [IW-1:0] pick;
    logic          found;
    logic [IW:0]   scan;
    logic          own_req;
    logic          xfer;

    // Round-robin pick: first requester after last_owner, wrapping modulo N_REQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        scan  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            scan = {1'b0, last_owner} + (IW+1)'(i);
            if (scan >= N_WRAP) begin
                scan = scan - N_WRAP;
            end
            if (!found && (|(req & (N_REQ'(1) << scan)))) begin
                found = 1'b1;
                pick  = scan[IW-1:0];
            end
        end
    end

    // Transfer path: owner's word goes straight to the fifo unless it is full.
    always_comb begin
        own_req   = |(req & (N_REQ'(1) << owner));
        xfer      = (state == GRANT) && own_req && !fifo_full;
        ack       = xfer ? (N_REQ'(1) << owner) : '0;
        fifo_push = xfer;
        fifo_d    = xfer ? DW'(din >> (owner * DW)) : '0;
    end

    // Next-state logic: grant from IDLE, release on burst end or withdrawal.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        burst_cnt_nxt  = burst_cnt;
        grant_id_nxt   = grant_id;
        busy_nxt       = busy;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt     = GRANT;
                    owner_nxt     = pick;
                    grant_id_nxt  = pick;
                    busy_nxt      = 1'b1;
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!own_req || (xfer && (burst_cnt == LAST_BEAT))) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                    grant_id_nxt   = '0;
                    busy_nxt       = 1'b0;
                    burst_cnt_nxt  = '0;
                end else if (xfer) begin
                    burst_cnt_nxt = burst_cnt + 4'd1;
                end
            end
        endcase
    end

    // State register; reset leaves last_owner at N_REQ-1 so req[0] wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(N_REQ - 1);
            burst_cnt  <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
            grant_id   <= grant_id_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, DW=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] din;
    logic        fifo_full;
    logic [3:0]  ack;
    logic        fifo_push;
    logic [3:0]  fifo_d;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [3:0] fq[$];

    fifo_wr_arbiter #(.N_REQ(4), .DW(4), .MAX_BURST(4), .IW(2)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .fifo_full(fifo_full),
        .ack(ack), .fifo_push(fifo_push), .fifo_d(fifo_d),
        .grant_id(grant_id), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0; fifo_full = 1'b0; din = '0;
        step(); step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = '0; din = '0; fifo_full = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got=%0h exp=0", grant_id); end
        req = 4'b1111; din = 16'hFFFF;
        step();
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got=%0h exp=0", ack); end
        checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push got=%0h exp=0", fifo_push); end
        checks++; if (fifo_d !== 4'h0) begin errors++; $display("FAIL reset_d got=%0h exp=0", fifo_d); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_clk got=%0h exp=0", busy); end
        req = '0; din = '0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0001; din = 16'h0001;
        #1;
        checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL single_idle_push got=%0h exp=0", fifo_push); end
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%0h exp=1", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_gid got=%0h exp=0", grant_id); end
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (fifo_push !== 1'b1 || ack !== 4'b0001) begin errors++; $display("FAIL single_push%0d got=%0h/%0h exp=1/1", k, fifo_push, ack); end
            checks++; if (fifo_d !== 4'(k)) begin errors++; $display("FAIL single_d%0d got=%0h exp=%0h", k, fifo_d, 4'(k)); end
            step();
            din[3:0] = 4'(k + 1);
        end
        #1;
        checks++; if (busy !== 1'b0 || fifo_push !== 1'b0) begin errors++; $display("FAIL single_bubble got=%0h/%0h exp=0/0", busy, fifo_push); end
        step();
        checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_regrant got=%0h/%0h exp=1/0", busy, grant_id); end
        #1;
        checks++; if (fifo_push !== 1'b1 || fifo_d !== 4'd5) begin errors++; $display("FAIL single_d5 got=%0h/%0h exp=1/5", fifo_push, fifo_d); end
        step();
        din[3:0] = 4'd6; req = '0;
        #1;
        checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL single_drop_push got=%0h exp=0", fifo_push); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_release got=%0h exp=0", busy); end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        din = 16'hDCBA; req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++; if (busy !== 1'b1 || grant_id !== 2'(order[n])) begin errors++; $display("FAIL rr_grant%0d got=%0h/%0h exp=1/%0h", n, busy, grant_id, order[n]); end
            for (int b = 0; b < 4; b++) begin
                #1;
                checks++; if (ack !== (4'b0001 << order[n]) || fifo_d !== 4'(10 + order[n])) begin errors++; $display("FAIL rr_xfer%0d_%0d got=%0h/%0h exp=%0h/%0h", n, b, ack, fifo_d, 4'b0001 << order[n], 4'(10 + order[n])); end
                step();
            end
            #1;
            checks++; if (busy !== 1'b0 || fifo_push !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d got=%0h/%0h exp=0/0", n, busy, fifo_push); end
        end
        req = '0;
        step();
    endtask

    task automatic test_stall();
        do_reset();
        din = 16'h0100; req = 4'b0100;
        step();
        checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL stall_grant got=%0h/%0h exp=2/1", grant_id, busy); end
        for (int w = 1; w <= 4; w++) begin
            if (w == 3) begin
                fifo_full = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    checks++; if (fifo_push !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL stall_nopush%0d got=%0h/%0h exp=0/0", s, fifo_push, ack); end
                    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL stall_hold%0d got=%0h/%0h exp=1/2", s, busy, grant_id); end
                    step();
                end
                fifo_full = 1'b0;
            end
            #1;
            checks++; if (fifo_push !== 1'b1 || ack !== 4'b0100 || fifo_d !== 4'(w)) begin errors++; $display("FAIL stall_w%0d got=%0h/%0h/%0h exp=1/4/%0h", w, fifo_push, ack, fifo_d, w); end
            step();
            din[11:8] = 4'(w + 1);
        end
        checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL stall_release got=%0h/%0h exp=0/0", busy, grant_id); end
        req = '0;
        step();
    endtask

    task automatic test_withdraw();
        do_reset();
        din = 16'h7654; req = 4'b1010;
        step();
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL wd_grant1 got=%0h exp=1", grant_id); end
        #1;
        checks++; if (ack !== 4'b0010 || fifo_d !== 4'h5) begin errors++; $display("FAIL wd_word got=%0h/%0h exp=2/5", ack, fifo_d); end
        step();
        req = 4'b1001;
        #1;
        checks++; if (fifo_push !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wd_nopush got=%0h/%0h exp=0/1", fifo_push, busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_release got=%0h exp=0", busy); end
        step();
        checks++; if (grant_id !== 2'd3 || busy !== 1'b1) begin errors++; $display("FAIL wd_next got=%0h/%0h exp=3/1", grant_id, busy); end
        #1;
        checks++; if (ack !== 4'b1000 || fifo_d !== 4'h7) begin errors++; $display("FAIL wd_word3 got=%0h/%0h exp=8/7", ack, fifo_d); end
        req = '0;
        step(); step();
    endtask

    task automatic test_async_reset();
        din = 16'h0900; req = 4'b0010;
        step();
        req = '0;
        step();
        req = 4'b0100;
        step();
        #1;
        checks++; if (fifo_push !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL ar_pre got=%0h/%0h exp=1/2", fifo_push, grant_id); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (fifo_push !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL ar_push got=%0h/%0h exp=0/0", fifo_push, ack); end
        checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL ar_regs got=%0h/%0h exp=0/0", busy, grant_id); end
        req = 4'b1010;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_held got=%0h exp=0", busy); end
        reset = 1'b1;
        step();
        checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL ar_first got=%0h/%0h exp=1/1", grant_id, busy); end
        req = '0;
        step(); step();
    endtask

    task automatic test_fifo_fill();
        int k = 1;
        int popped = 0;
        int full_cycles = 0;
        bit popping = 0;
        bit saw_full = 0;
        bit pushed, acked, do_pop;
        logic [3:0] pd, w;
        do_reset();
        fq.delete();
        req = 4'b0001; din = 16'h0001;
        for (int cyc = 0; cyc < 200 && popped < 17; cyc++) begin
            #1;
            if (fifo_full) begin
                saw_full = 1;
                checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL fill_push_full got=%0h exp=0", fifo_push); end
            end
            pushed = fifo_push; pd = fifo_d; acked = ack[0];
            do_pop = popping && (fq.size() > 0);
            step();
            if (do_pop) begin
                w = fq.pop_front();
                checks++; if (w !== 4'(popped + 1)) begin errors++; $display("FAIL fill_order%0d got=%0h exp=%0h", popped, w, 4'(popped + 1)); end
                popped++;
            end
            if (pushed) fq.push_back(pd);
            if (acked) begin
                k++;
                if (k > 17) req = '0;
                else din[3:0] = 4'(k);
            end
            fifo_full = (fq.size() == 16);
            if (saw_full && !popping) begin
                full_cycles++;
                if (full_cycles == 3) popping = 1;
            end
        end
        checks++; if (popped != 17) begin errors++; $display("FAIL fill_count got=%0d exp=17", popped); end
        checks++; if (!saw_full) begin errors++; $display("FAIL fill_saw_full got=0 exp=1"); end
        fifo_full = 1'b0; req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_withdraw();
        test_async_reset();
        test_fifo_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
